// File: rtl/cbd_sampler_if.sv
// PRF word stream into the CBD sampler: 32-bit words, valid/ready.
// Handshake: a word transfers on a rising clock edge where din_valid_i
// and din_ready_o are both high. The master holds din_i stable while
// din_valid_i is high. din_ready_o may depend only on sampler state,
// never on din_valid_i.
interface cbd_sampler_if;
  logic [31:0] din_i;
  logic        din_valid_i;
  logic        din_ready_o;

  modport master (output din_i, output din_valid_i, input din_ready_o);
  modport slave  (input din_i, input din_valid_i, output din_ready_o);
endinterface

// File: rtl/cbd_sampler.sv
// cbd_sampler: centered-binomial sampler for Kyber. Turns the PRF bit
// stream into a 256-coefficient polynomial in mod-q form.
// Optional feature macro: CBD_ETA3_EN adds eta3_i and the eta=3 path
// (6 bits per coefficient, 48-word budget). Without it, eta is fixed at 2.
// poly_o is laid out as poly_t: element i is coefficient i, 12 bits each.
module cbd_sampler #(
  parameter int Q = 3329,
  parameter int N = 256
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
`ifdef CBD_ETA3_EN
  input  logic               eta3_i,
`endif
  cbd_sampler_if.slave       din_if,
  output logic [N-1:0][11:0] poly_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  localparam int          IW = $clog2(N);
  localparam logic [11:0] QC = 12'(Q);

  state_e             state_q, state_d;
  logic [63:0]        bits_q, bits_d;
  logic [6:0]         cnt_q, cnt_d;
  logic [8:0]         idx_q, idx_d;
  logic [5:0]         wcnt_q, wcnt_d;
  logic [N-1:0][11:0] poly_q, poly_d;
`ifdef CBD_ETA3_EN
  logic               w6_q, w6_d;
`endif

  logic [6:0]  w;
  logic [5:0]  budget;
  logic        ready, accept, emit;
  logic [2:0]  a, b;
  logic [11:0] coef;
  logic [63:0] din_ext;

  // Bits per coefficient and word budget follow the eta latched at start.
`ifdef CBD_ETA3_EN
  assign w      = w6_q ? 7'd6 : 7'd4;
  assign budget = w6_q ? 6'd48 : 6'd32;
`else
  assign w      = 7'd4;
  assign budget = 6'd32;
`endif

  // A new word is only taken when it fits above the unread bits.
  assign ready   = (state_q == RUN) && (cnt_q <= 7'd32) && (wcnt_q < budget);
  assign accept  = ready && din_if.din_valid_i;
  assign emit    = (state_q == RUN) && (cnt_q >= w);
  assign din_ext = {32'd0, din_if.din_i};

  // Coefficient from the low W buffer bits: popcount difference, negatives folded to Q+v.
  always_comb begin
    a = 3'(bits_q[0]) + 3'(bits_q[1]);
    b = 3'(bits_q[2]) + 3'(bits_q[3]);
`ifdef CBD_ETA3_EN
    if (w6_q) begin
      a = 3'(bits_q[0]) + 3'(bits_q[1]) + 3'(bits_q[2]);
      b = 3'(bits_q[3]) + 3'(bits_q[4]) + 3'(bits_q[5]);
    end
`endif
    coef = (a >= b) ? {9'd0, a - b} : QC - {9'd0, b - a};
  end

  // Next-state control: IDLE -> RUN on start, RUN -> DONE after the last coefficient.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (emit && (idx_q == 9'(N - 1))) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next state: start clears the buffer; emit shifts first, then the word lands at the reduced count.
  always_comb begin
    bits_d = bits_q;
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    wcnt_d = wcnt_q;
    poly_d = poly_q;
`ifdef CBD_ETA3_EN
    w6_d   = w6_q;
`endif
    if ((state_q == IDLE) && start_i) begin
      bits_d = '0;
      cnt_d  = '0;
      idx_d  = '0;
      wcnt_d = '0;
`ifdef CBD_ETA3_EN
      w6_d   = eta3_i;
`endif
    end else begin
      if (emit) begin
        poly_d[idx_q[IW-1:0]] = coef;
        idx_d  = idx_q + 9'd1;
        bits_d = bits_q >> w;
        cnt_d  = cnt_q - w;
      end
      if (accept) begin
        bits_d = bits_d | (din_ext << cnt_d);
        cnt_d  = cnt_d + 7'd32;
        wcnt_d = wcnt_q + 6'd1;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      bits_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      wcnt_q  <= '0;
      poly_q  <= '0;
`ifdef CBD_ETA3_EN
      w6_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bits_q  <= bits_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      poly_q  <= poly_d;
`ifdef CBD_ETA3_EN
      w6_q    <= w6_d;
`endif
    end
  end

  assign din_if.din_ready_o = ready;
  assign poly_o  = poly_q;
  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);
  assign state_o = state_q;

endmodule

// File: tb/tb_cbd_sampler.sv
// Testbench for cbd_sampler: random and patterned PRF streams, a bit-level
// reference model, and a monitor that checks poly_o on every done_o pulse.
module tb_cbd_sampler;
  localparam int Q = 3329;
  localparam int N = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic eta3 = 1'b0;
  logic [N-1:0][11:0] poly;
  logic busy, done;
  logic [1:0] state;

  always #5 clk = ~clk;

  cbd_sampler_if din_if ();

  cbd_sampler #(.Q(Q), .N(N)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
`ifdef CBD_ETA3_EN
    .eta3_i  (eta3),
`endif
    .din_if  (din_if),
    .poly_o  (poly),
    .busy_o  (busy),
    .done_o  (done),
    .state_o (state)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [11:0] exp_q[$];
  logic [31:0] stim_w[48];
  int run_cyc = 0;
  bit done_seen = 1'b0;
  bit done_exact = 1'b1;
  int exp_done_cyc = 258;
  logic [11:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference model: coefficient i reads 2*eta consecutive stream bits.
  function automatic logic [11:0] model_coef(input int i, input bit e3);
    int eta, base, a, b, v, k;
    eta = e3 ? 3 : 2;
    base = i * 2 * eta;
    a = 0;
    b = 0;
    for (int j = 0; j < eta; j++) begin
      k = base + j;
      a += int'(stim_w[k / 32][k % 32]);
      k = base + eta + j;
      b += int'(stim_w[k / 32][k % 32]);
    end
    v = a - b;
    return (v < 0) ? 12'(Q + v) : 12'(v);
  endfunction

  function automatic int count_nonzero();
    int n = 0;
    for (int i = 0; i < N; i++) if (poly[i] != 12'd0) n++;
    return n;
  endfunction

  function automatic int count_model_diff(input bit e3);
    int n = 0;
    for (int i = 0; i < N; i++) if (poly[i] !== model_coef(i, e3)) n++;
    return n;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    run_cyc = run_cyc + 1;
    if (done === 1'b1) begin
      done_seen = 1'b1;
      checks++;
      if (exp_q.size() < N) begin
        errors++;
        $display("FAIL done_unexpected: done_o=1 with %0d coefficients queued, required %0d", exp_q.size(), N);
      end else begin
        checks++;
        if (done_exact ? (run_cyc != exp_done_cyc) : (run_cyc < exp_done_cyc)) begin
          errors++;
          $display("FAIL done_cycle: done_o in cycle %0d, required %s%0d", run_cyc,
                   done_exact ? "" : ">=", exp_done_cyc);
        end
        for (int i = 0; i < N; i++) begin
          mon_e = exp_q.pop_front();
          checks++;
          if (poly[i] !== mon_e) begin
            errors++;
            $display("FAIL coef[%0d]: got %0d, required %0d", i, poly[i], mon_e);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // pat: 0 zeros, 1 0xCCCCCCCC, 2 0x33333333, 3 eta3 pattern, else random.
  task automatic set_words(input int pat);
    for (int i = 0; i < 48; i++) begin
      case (pat)
        0:       stim_w[i] = 32'h0;
        1:       stim_w[i] = 32'hCCCCCCCC;
        2:       stim_w[i] = 32'h33333333;
        3:       stim_w[i] = (i % 3 == 0) ? 32'h38E38E38 : (i % 3 == 1) ? 32'h8E38E38E : 32'hE38E38E3;
        default: stim_w[i] = $urandom();
      endcase
    end
  endtask

  // mode: 0 valid always, 1 valid toggling (low first), 2 random valid.
  task automatic run_poly(input string tag, input bit e3, input int mode,
                          input int start_at, input int rst_at);
    int k, nwords, guard, ready_viol;
    nwords = e3 ? 48 : 32;
    if (rst_at == 0)
      for (int i = 0; i < N; i++) exp_q.push_back(model_coef(i, e3));
    done_exact   = (mode == 0);
    exp_done_cyc = (mode == 1) ? 259 : 258;
    done_seen    = 1'b0;
    start = 1'b1;
    eta3  = e3;
    @(posedge clk); #1;
    start = 1'b0;
    run_cyc = 0;
    k = 0;
    guard = 0;
    ready_viol = 0;
    while (!done_seen && guard < 3000) begin
      case (mode)
        0:       din_if.din_valid_i = 1'b1;
        1:       din_if.din_valid_i = run_cyc[0];
        default: din_if.din_valid_i = ($urandom_range(0, 3) != 0);
      endcase
      din_if.din_i = (k < nwords) ? stim_w[k] : $urandom();
      start = (start_at > 0) && (run_cyc == start_at);
      rst   = (rst_at > 0) && (run_cyc == rst_at);
      @(negedge clk);
      if (run_cyc == 1) begin
        check({tag, "_ready_cycle1"}, 32'(din_if.din_ready_o), 1);
        check({tag, "_busy_cycle1"}, 32'(busy), 1);
      end
      if (din_if.din_ready_o && k >= nwords) ready_viol++;
      if (din_if.din_valid_i && din_if.din_ready_o) k++;
      @(posedge clk); #1;
      if (rst) begin
        rst = 1'b0;
        break;
      end
      guard++;
    end
    start = 1'b0;
    din_if.din_valid_i = 1'b0;
    if (rst_at > 0) begin
      @(negedge clk);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_ready"}, 32'(din_if.din_ready_o), 0);
      check({tag, "_state"}, 32'(state), 0);
      check({tag, "_poly_nonzero"}, 32'(count_nonzero()), 0);
      repeat (5) @(posedge clk);
      #1;
    end else begin
      check({tag, "_done_seen"}, 32'(done_seen), 1);
      if (!done_seen) exp_q.delete();
      @(negedge clk);
      check({tag, "_words"}, 32'(k), 32'(nwords));
      check({tag, "_ready_after_budget"}, 32'(ready_viol), 0);
      check({tag, "_busy_after"}, 32'(busy), 0);
      din_if.din_valid_i = 1'b1;
      din_if.din_i = $urandom();
      repeat (6) @(negedge clk);
      check({tag, "_poly_stable"}, 32'(count_model_diff(e3)), 0);
      din_if.din_valid_i = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // ---------------- stimulus sequence and report ----------------
  initial begin
    din_if.din_i = 32'h0;
    din_if.din_valid_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_ready", 32'(din_if.din_ready_o), 0);
    check("reset_state", 32'(state), 0);
    check("reset_poly_nonzero", 32'(count_nonzero()), 0);
    @(posedge clk); #1;

    set_words(0); run_poly("zeros", 1'b0, 0, 0, 0);
    set_words(1); run_poly("cc", 1'b0, 0, 0, 0);
    set_words(2); run_poly("h33", 1'b0, 0, 0, 0);
    set_words(1); run_poly("cc_toggle", 1'b0, 1, 0, 0);
    set_words(4); run_poly("start_mid", 1'b0, 0, 100, 0);
    set_words(4); run_poly("reset_mid", 1'b0, 0, 0, 150);
    set_words(4); run_poly("after_reset", 1'b0, 0, 0, 0);
    for (int r = 0; r < 3; r++) begin
      set_words(4);
      run_poly("rand_gaps", 1'b0, 2, 0, 0);
    end
`ifdef CBD_ETA3_EN
    set_words(3); run_poly("eta3_pat", 1'b1, 0, 0, 0);
    set_words(4); run_poly("eta3_rand", 1'b1, 0, 0, 0);
    set_words(4); run_poly("eta3_gaps", 1'b1, 2, 0, 0);
    set_words(4); run_poly("eta3_start_mid", 1'b1, 0, 100, 0);
    set_words(4); run_poly("eta2_after_eta3", 1'b0, 2, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cbd_sampler.md
# cbd_sampler

Centered-binomial-distribution sampler for the Kyber KEM datapath. It consumes the PRF byte stream (32-bit words, valid/ready) and builds a full 256-coefficient polynomial in mod-q form (q = 3329). The polynomial is presented as a `poly_t` that drives the polynomial inputs of the NTT wrapper directly. `done_o` tells the controller when the result can be handed to the NTT stage.

## Interface

Parameters:
- `Q`, default 3329: modulus; negative samples map to Q+v.
- `N`, default 256: coefficients per polynomial.

Ports (one clock; reset is synchronous and active-high):
- `clk_i`, in, 1: clock; all logic on the rising edge.
- `rst_i`, in, 1: synchronous active-high reset.
- `start_i`, in, 1: start a new polynomial; honoured in IDLE only.
- `eta3_i`, in, 1: 1 selects eta=3, 0 selects eta=2. Present only with `CBD_ETA3_EN`.
- `din_i`, in, 32: PRF word; byte 0 of the stream is in `din_i[7:0]`.
- `din_valid_i`, in, 1: `din_i` is valid.
- `din_ready_o`, out, 1: sampler accepts `din_i` this cycle.
- `poly_o`, out, `poly_t` (256×12): coefficient i is in element i, range 0..Q-1.
- `busy_o`, out, 1: sampling in progress.
- `done_o`, out, 1: one-cycle pulse once all 256 coefficients are written.

## Operation

- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start_i`.
  - RUN → DONE after coefficient 255 is written.
  - DONE → IDLE unconditionally after one cycle.
- On start:
  - Latch W = 4 (eta=2) or W = 6 (eta=3); `eta3_i` is sampled only here.
  - Clear the bit buffer, bit count `cnt`, coefficient index `idx` and word count.
  - `poly_o` is not cleared; each coefficient is overwritten as it is produced.
- Bit buffer: 64 bits, LSB-first stream order.
  - `din_ready_o` = RUN && `cnt` ≤ 32 && word count < 32 (eta=2) or < 48 (eta=3).
  - Accept: the word is appended at bit position `cnt`, then `cnt` += 32.
- Emit: in RUN with `cnt` ≥ W, produce one coefficient per cycle from `buf[W-1:0]`.
  - eta=2: a = popcount(`buf[1:0]`), b = popcount(`buf[3:2]`).
  - eta=3: a = popcount(`buf[2:0]`), b = popcount(`buf[5:3]`).
  - v = a − b, in [−eta, eta]. Write `poly_o[idx]` = v when v ≥ 0, else Q+v.
  - Then shift `buf` right by W, `cnt` −= W, `idx`++.
- Accept and emit in the same cycle: shift first, then append the new word at position `cnt`−W. Net `cnt` = `cnt` − W + 32.
- Word budget: 1024 bits (32 words) for eta=2, 1536 bits (48 words) for eta=3.
  - No leftover bits.
  - Words beyond the budget are never accepted.
- Arithmetic: `cnt` is 7 bits (max 64), `idx` is 9 bits, coefficient is 12 bits.
  - Q+v computed at 12-bit width; no wrap beyond Q−1.

## Timing

- Reset values:
  - FSM in IDLE.
  - `busy_o` = 0, `done_o` = 0, `din_ready_o` = 0.
  - `poly_o` all zeros.
  - Bit buffer, `cnt`, `idx` and word count all zero.
- `busy_o` is high in RUN and DONE.
- Cycle after start: `din_ready_o` = 1.
- Latency with `din_valid_i` held high:
  - First word is accepted in cycle 1 after the start cycle.
  - Coefficients are emitted in cycles 2..257, no bubbles, for both eta values.
  - `done_o` is high in cycle 258.
- Input gaps: emission stalls only while `cnt` < W. Resulting `poly_o` is identical to the gap-free case.
- `start_i` in RUN or DONE: ignored, no effect on the current polynomial.
- `rst_i` mid-operation: next cycle is in the reset state. Partial `poly_o` is cleared and no `done_o` is issued.
- `poly_o` is stable from `done_o` until the next start.

## Configuration

- `CBD_ETA3_EN` defined:
  - `eta3_i` port exists.
  - Both W = 4 and W = 6 are supported; 48-word budget for eta=3.
- `CBD_ETA3_EN` undefined:
  - `eta3_i` port is absent.
  - W is fixed at 4; word budget fixed at 32.
  - All eta=3 logic is removed.

## Test plan

- All-zero stream, eta=2, valid always high → all 256 coefficients 0; exactly 32 words accepted; `done_o` in cycle 258 after start.
- Words 0xCCCCCCCC, eta=2 → every coefficient 3327 (a=0, b=2). Words 0x33333333 → every coefficient 2.
- eta=3 (`CBD_ETA3_EN`), repeating words 0x38E38E38, 0x8E38E38E, 0xE38E38E3 → every coefficient 3326; exactly 48 words accepted; `done_o` in cycle 258.
- Same 0xCCCCCCCC stream with `din_valid_i` toggled every cycle → identical `poly_o`; `done_o` later than 258; `din_ready_o` never high after word 32.
- `start_i` pulsed at cycle 100 of a run → ignored, result unchanged.
- `rst_i` at cycle 150 → `poly_o` all 0, `busy_o` 0, no `done_o`. A new start then completes normally.
